// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a valid/ready handshake on each side.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | WIDTH iterations of shift-add or restoring divide
// FIXUP | two's-complement sign correction and result selection
// DONE  | result presented, out_valid high until taken
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] left_operand,
    input  logic [WIDTH-1:0] right_operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIXUP, DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic               neg_q, neg_r;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   dvsr;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q, dbz_q;

    logic               accept;
    logic               l_signed, r_signed, l_neg, r_neg;
    logic [WIDTH-1:0]   l_mag, r_mag;
    logic               div_zero, div_ovf, bypass;

    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept = in_valid && in_ready && !flush;

    assign l_signed = (md_op == OP_MULH) || (md_op == OP_MULHSU) ||
                      (md_op == OP_DIV) || (md_op == OP_REM);
    assign r_signed = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
    assign l_neg = l_signed && left_operand[WIDTH-1];
    assign r_neg = r_signed && right_operand[WIDTH-1];
    // Negating the most-negative value yields 2^(WIDTH-1), the correct unsigned magnitude.
    assign l_mag = l_neg ? -left_operand : left_operand;
    assign r_mag = r_neg ? -right_operand : right_operand;

    assign div_zero = md_op[2] && (right_operand == '0);
    assign div_ovf = ((md_op == OP_DIV) || (md_op == OP_REM)) &&
                     (left_operand == MOST_NEG) && (right_operand == '1);
    assign bypass = div_zero || div_ovf;

    // Multiply: high half accumulates the multiplicand, whole register shifts right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, dvsr} : '0);
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend out and quotient in.
    logic [WIDTH:0]     div_part, div_diff;
    logic [2*WIDTH-1:0] div_next;
    assign div_part = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_diff = div_part - {1'b0, dvsr};
    assign div_next = {(div_diff[WIDTH] ? div_part[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                       prod[WIDTH-2:0], ~div_diff[WIDTH]};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_val;
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    assign rem_fix = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

    always_comb begin
        fix_val = '0;
        unique case (op_q)
            OP_MUL:                       fix_val = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_val = quo_fix;
            OP_REM, OP_REMU:              fix_val = rem_fix;
            default:                      fix_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = bypass ? DONE : BUSY;
            BUSY:    if (cnt == CW'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            prod     <= '0;
            dvsr     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (flush) begin
            cnt    <= '0;
            zero_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    op_q  <= md_op;
                    neg_q <= l_neg ^ r_neg;
                    neg_r <= l_neg;
                    if (div_zero) begin
                        result_q <= md_op[1] ? left_operand : '1;
                        zero_q   <= md_op[1] && (left_operand == '0);
                        dbz_q    <= 1'b1;
                        cnt      <= '0;
                    end else if (div_ovf) begin
                        result_q <= md_op[1] ? '0 : MOST_NEG;
                        zero_q   <= md_op[1];
                        dbz_q    <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        prod <= {{WIDTH{1'b0}}, (md_op[2] ? l_mag : r_mag)};
                        dvsr <= md_op[2] ? r_mag : l_mag;
                        cnt  <= CW'(WIDTH);
                    end
                end
                BUSY: begin
                    cnt  <= cnt - CW'(1);
                    prod <= op_q[2] ? div_next : mul_next;
                end
                FIXUP: begin
                    result_q <= fix_val;
                    zero_q   <= (fix_val == '0);
                    dbz_q    <= 1'b0;
                end
                DONE: if (out_ready) begin
                    zero_q <= 1'b0;
                    dbz_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign zero_flag = zero_q;
    assign div_by_zero = dbz_q;

endmodule
